// File: rtl/noc_pkg.sv
// ============================================================================
// noc_pkg : shared register offsets, flit codes, STATUS bits and TX states
// Rev 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

  localparam logic [4:0] OFF_STATUS  = 5'd0;
  localparam logic [4:0] OFF_TX_DEST = 5'd4;
  localparam logic [4:0] OFF_TX_DATA = 5'd8;
  localparam logic [4:0] OFF_RX_DATA = 5'd12;
  localparam logic [4:0] OFF_CTRL    = 5'd16;

  localparam logic [31:0] MMR_SPAN = 32'd20;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_RXV  = 2;
  localparam int ST_ERR  = 3;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HEAD = 2'd1,
    TX_TAIL = 2'd2
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/noc_tx_fsm.sv
// ============================================================================
// noc_tx_fsm : two-flit packet sequencer; stall timeout under NOC_TX_TIMEOUT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module noc_tx_fsm
  import noc_pkg::*;
#(
  parameter int FLIT_W         = 34,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       tx_dest,
  input  logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              busy,
  output logic              done,
  output logic              err
);

  tx_state_e r_state, w_state_nxt;
  logic      r_done,  w_done_nxt;

`ifdef NOC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic             w_timeout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_done  <= 1'b0;
`ifdef NOC_TX_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
`ifdef NOC_TX_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    tx_valid    = 1'b0;
    tx_flit     = '0;
`ifdef NOC_TX_TIMEOUT_EN
    w_err_nxt   = r_err;
    w_cnt_nxt   = '0;
    w_timeout   = 1'b0;
`endif
    case (r_state)
      TX_IDLE: begin
        if (start) begin
          w_state_nxt = TX_HEAD;
          w_done_nxt  = 1'b0;
`ifdef NOC_TX_TIMEOUT_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end
      TX_HEAD: begin
        tx_valid                 = 1'b1;
        tx_flit[FLIT_W-1 -: 2]   = FLIT_HEAD;
        tx_flit[31:0]            = tx_dest;
        if (tx_ready) w_state_nxt = TX_TAIL;
      end
      TX_TAIL: begin
        tx_valid                 = 1'b1;
        tx_flit[FLIT_W-1 -: 2]   = FLIT_TAIL;
        tx_flit[31:0]            = tx_data;
        if (tx_ready) begin
          w_state_nxt = TX_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
`ifdef NOC_TX_TIMEOUT_EN
    // The stall that would bring the count to TIMEOUT_CYCLES abandons the packet.
    if (tx_valid && !tx_ready) begin
      if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        w_timeout   = 1'b1;
        w_state_nxt = TX_IDLE;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
`endif
  end

  assign busy = (r_state != TX_IDLE);
  assign done = r_done;
`ifdef NOC_TX_TIMEOUT_EN
  assign err  = r_err;
`else
  assign err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/noc_mmr_bridge.sv
// ============================================================================
// noc_mmr_bridge : MEM-stage MMR window, TX packetiser and RX capture
// Rev 1.0 -- NOC_TX_TIMEOUT_EN enables the tx stall timeout
// ============================================================================
`default_nettype none

module noc_mmr_bridge
  import noc_pkg::*;
#(
  parameter logic [31:0] MMR_BASE       = 32'd4000,
  parameter int          FLIT_W         = 34,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_wr_en,
  input  logic              mem_rd_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_hit,
  output logic              noc_tx_valid,
  input  logic              noc_tx_ready,
  output logic [FLIT_W-1:0] noc_tx_flit,
  input  logic              noc_rx_valid,
  output logic              noc_rx_ready,
  input  logic [FLIT_W-1:0] noc_rx_flit
);

  logic [31:0] w_off;
  logic [4:0]  w_reg;
  logic        w_busy, w_done, w_err;
  logic        w_wr, w_rd, w_start, w_rx_take;
  logic [31:0] w_status;
  logic [31:0] r_tx_dest, r_tx_data, r_rx_data;
  logic        r_rx_valid;

  assign w_off   = mem_addr - MMR_BASE;
  assign w_reg   = w_off[4:0];
  assign mem_hit = (mem_addr >= MMR_BASE) && (w_off < MMR_SPAN) && (mem_addr[1:0] == 2'b00);

  // Configuration writes are locked out for the whole packet so the flits stay stable.
  assign w_wr      = mem_hit && mem_wr_en && !w_busy;
  assign w_rd      = mem_hit && mem_rd_en;
  assign w_start   = w_wr && (w_reg == OFF_CTRL) && mem_wdata[0];
  assign w_rx_take = noc_rx_valid && noc_rx_ready &&
                     (noc_rx_flit[FLIT_W-1 -: 2] == FLIT_TAIL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_dest  <= '0;
      r_tx_data  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_wr && (w_reg == OFF_TX_DEST)) r_tx_dest <= mem_wdata;
      if (w_wr && (w_reg == OFF_TX_DATA)) r_tx_data <= mem_wdata;
      if (w_rd && (w_reg == OFF_RX_DATA)) r_rx_valid <= 1'b0;
      if (w_rx_take) begin
        r_rx_data  <= noc_rx_flit[31:0];
        r_rx_valid <= 1'b1;
      end
    end
  end

  assign noc_rx_ready = !r_rx_valid;

  always_comb begin
    w_status           = '0;
    w_status[ST_BUSY]  = w_busy;
    w_status[ST_DONE]  = w_done;
    w_status[ST_RXV]   = r_rx_valid;
    w_status[ST_ERR]   = w_err;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_hit) begin
      case (w_reg)
        OFF_STATUS:  mem_rdata = w_status;
        OFF_TX_DEST: mem_rdata = r_tx_dest;
        OFF_TX_DATA: mem_rdata = r_tx_data;
        OFF_RX_DATA: mem_rdata = r_rx_data;
        default:     mem_rdata = '0;
      endcase
    end
  end

  noc_tx_fsm #(
    .FLIT_W         (FLIT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tx_fsm (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .tx_dest  (r_tx_dest),
    .tx_data  (r_tx_data),
    .tx_valid (noc_tx_valid),
    .tx_ready (noc_tx_ready),
    .tx_flit  (noc_tx_flit),
    .busy     (w_busy),
    .done     (w_done),
    .err      (w_err)
  );

endmodule

`default_nettype wire
